// File: rtl/beta_if_stage_pkg.sv
// Shared IF-stage types: prefetch buffer entry layout, NOP encoding, default boot PC.
package beta_if_stage_pkg;

    localparam int          PB_DATA_W    = 32;
    localparam int          PB_ADDR_W    = 32;
    localparam logic [31:0] PB_NOP       = 32'h0000_0013;
    localparam logic [31:0] PB_BOOT_ADDR = 32'h0000_0080;

    typedef struct packed {
        logic [PB_ADDR_W-1:0] pc;
        logic [PB_DATA_W-1:0] instr;
    } pb_entry_t;

endpackage

// File: rtl/beta_pb_fifo.sv
// Show-ahead synchronous FIFO; rdata_o is the head while count_o != 0, clr_i wins over push/pop.
// Pushes at full are dropped (and flagged in simulation); pops on empty are ignored.
module beta_pb_fifo #(
    parameter int  Width = 64,
    parameter int  Depth = 4,
    localparam int CntW  = $clog2(Depth + 1),
    localparam int PtrW  = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             full, do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign do_push = push_i && !full && !clr_i;
    assign do_pop  = pop_i && (count_q != '0) && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !clr_i && push_i) begin
            assert (!full) else $error("beta_pb_fifo: push at full dropped");
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited fetch issue, PC tagging, flush/discard; 1-cycle return-to-valid.
// Fetch stalls when buffered + in-flight reaches Depth; BETA_PB_BYPASS_EN forwards returns straight through when empty.
module beta_prefetch_buffer
    import beta_if_stage_pkg::*;
#(
    parameter int                   DataWidth = 32,
    parameter int                   AddrWidth = 32,
    parameter int                   Depth     = 4,
    parameter logic [AddrWidth-1:0] BootAddr  = AddrWidth'(PB_BOOT_ADDR)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         pb_fetch_en_o,
    output logic [AddrWidth-1:0]         pb_fetch_addr_o,
    input  logic                         pb_fu_busy_i,
    input  logic                         pb_new_instr_i,
    input  logic [DataWidth-1:0]         pb_instr_i,
    input  logic                         pb_flush_i,
    input  logic [AddrWidth-1:0]         pb_flush_pc_i,
    output logic                         pb_valid_o,
    output logic [DataWidth-1:0]         pb_instr_o,
    output logic [AddrWidth-1:0]         pb_pc_o,
    input  logic                         pb_ready_i,
    output logic [$clog2(Depth+1)-1:0]   pb_count_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int EntW = AddrWidth + DataWidth;

    logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d;
    logic                 outst_q, outst_d, discard_q, discard_d;
    logic                 fetch_en, issue, accept, bypass, fifo_push, fifo_pop;
    logic [EntW-1:0]      head_ent;
    logic [CntW-1:0]      count;

    assign fetch_en = !rst_i && !pb_flush_i && !discard_q
                      && ((int'(count) + int'(outst_q)) < Depth);
    assign issue    = fetch_en && !pb_fu_busy_i;
    // Returns with nothing outstanding (e.g. the tail of a pre-reset fetch) are dropped.
    assign accept   = pb_new_instr_i && outst_q && !discard_q && !pb_flush_i;

`ifdef BETA_PB_BYPASS_EN
    assign bypass = accept && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = accept && !(bypass && pb_ready_i);
    assign fifo_pop  = pb_ready_i && (count != '0);

    beta_pb_fifo #(
        .Width (EntW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (pb_flush_i),
        .push_i  (fifo_push),
        .wdata_i ({pend_pc_q, pb_instr_i}),
        .pop_i   (fifo_pop),
        .rdata_o (head_ent),
        .count_o (count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        if (pb_new_instr_i) begin
            outst_d   = 1'b0;
            discard_d = 1'b0;
        end
        if (pb_flush_i) begin
            fetch_pc_d = pb_flush_pc_i;
            if (outst_q && !pb_new_instr_i) discard_d = 1'b1;
        end else if (issue) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + AddrWidth'(4);
            outst_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= BootAddr;
            pend_pc_q  <= '0;
            outst_q    <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        pb_instr_o = DataWidth'(PB_NOP);
        pb_pc_o    = '0;
        if (bypass) begin
            pb_instr_o = pb_instr_i;
            pb_pc_o    = pend_pc_q;
        end else if (count != '0) begin
            {pb_pc_o, pb_instr_o} = head_ent;
        end
    end

    assign pb_valid_o      = (count != '0) || bypass;
    assign pb_count_o      = count;
    assign pb_fetch_en_o   = fetch_en;
    assign pb_fetch_addr_o = fetch_pc_q;

endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// Bench for beta_prefetch_buffer: vector table, directed flush/reset/bypass sequences, random run vs queue model.
`timescale 1ns/1ps
module tb_beta_prefetch_buffer;
    import beta_if_stage_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef BETA_PB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en, busy, nw, flush, valid, ready;
    logic [31:0]   fetch_addr, ins_i, flush_pc, ins_o, pc_o;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    beta_prefetch_buffer #(
        .DataWidth (32), .AddrWidth (32), .Depth (DEPTH), .BootAddr (32'h80)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .pb_fetch_en_o (fetch_en), .pb_fetch_addr_o (fetch_addr),
        .pb_fu_busy_i (busy), .pb_new_instr_i (nw), .pb_instr_i (ins_i),
        .pb_flush_i (flush), .pb_flush_pc_i (flush_pc),
        .pb_valid_o (valid), .pb_instr_o (ins_o), .pb_pc_o (pc_o),
        .pb_ready_i (ready), .pb_count_o (count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h1000_0000 ^ pc;
    endfunction

    task automatic drv(input logic b, input logic n, input logic [31:0] ins,
                       input logic r, input logic f, input logic [31:0] fpc);
        busy = b; nw = n; ins_i = ins; ready = r; flush = f; flush_pc = fpc;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; busy = 0; nw = 0; ins_i = 0; ready = 0; flush = 0; flush_pc = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic busy, nw, rdy, fl;
        logic [31:0] ins, flpc;
        logic e_en; logic [31:0] e_addr; logic e_vld; int e_cnt;
        logic [31:0] e_pc, e_ins;
    } vec_t;

    function automatic vec_t mk(input logic b, input logic n, input logic [31:0] ins,
                                input logic r, input logic f, input logic [31:0] fpc,
                                input logic en, input logic [31:0] addr, input logic v,
                                input int c, input logic [31:0] pc, input logic [31:0] hi);
        vec_t t;
        t.busy = b; t.nw = n; t.ins = ins; t.rdy = r; t.fl = f; t.flpc = fpc;
        t.e_en = en; t.e_addr = addr; t.e_vld = v; t.e_cnt = c; t.e_pc = pc; t.e_ins = hi;
        return t;
    endfunction

    vec_t tbl[11];

    // Random-run reference model and fetch-unit emulation
    pb_entry_t   q[$];
    logic [31:0] m_pc, m_pend;
    bit          m_out, m_disc;

    initial begin
        // Reset state, sampled after the first reset edge
        rst = 1'b1; busy = 0; nw = 0; ins_i = 0; ready = 0; flush = 0; flush_pc = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_count", count, 0);
        chk("rst_fetch_en", fetch_en, 0);
        chk("rst_addr", fetch_addr, 32'h80);
        chk("rst_instr", ins_o, NOP);
        chk("rst_pc", pc_o, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Fill to Depth with ready low, one pop, push+pop at count 3, then flush
        tbl[0]  = mk(0, 0, 0,               0, 0, 0,      1, 32'h80, 0,   0, 0,      NOP);
        tbl[1]  = BYP ? mk(0, 1, instr_of(32'h80), 0, 0, 0, 1, 32'h84, 1, 0, 32'h80, instr_of(32'h80))
                      : mk(0, 1, instr_of(32'h80), 0, 0, 0, 1, 32'h84, 0, 0, 0,      NOP);
        tbl[2]  = mk(0, 1, instr_of(32'h84), 0, 0, 0,      1, 32'h88, 1,   1, 32'h80, instr_of(32'h80));
        tbl[3]  = mk(0, 1, instr_of(32'h88), 0, 0, 0,      1, 32'h8C, 1,   2, 32'h80, instr_of(32'h80));
        tbl[4]  = mk(0, 1, instr_of(32'h8C), 0, 0, 0,      0, 32'h90, 1,   3, 32'h80, instr_of(32'h80));
        tbl[5]  = mk(0, 0, 0,               0, 0, 0,      0, 32'h90, 1,   4, 32'h80, instr_of(32'h80));
        tbl[6]  = mk(0, 0, 0,               1, 0, 0,      0, 32'h90, 1,   4, 32'h80, instr_of(32'h80));
        tbl[7]  = mk(0, 0, 0,               0, 0, 0,      1, 32'h90, 1,   3, 32'h84, instr_of(32'h84));
        tbl[8]  = mk(0, 1, instr_of(32'h90), 1, 0, 0,      0, 32'h94, 1,   3, 32'h84, instr_of(32'h84));
        tbl[9]  = mk(0, 0, 0,               1, 1, 32'h200, 0, 32'h94, 1,  3, 32'h88, instr_of(32'h88));
        tbl[10] = mk(0, 0, 0,               0, 0, 0,      1, 32'h200, 0,  0, 0,      NOP);
        foreach (tbl[i]) begin
            drv(tbl[i].busy, tbl[i].nw, tbl[i].ins, tbl[i].rdy, tbl[i].fl, tbl[i].flpc);
            chk($sformatf("tbl%0d_en", i),    fetch_en,   tbl[i].e_en);
            chk($sformatf("tbl%0d_addr", i),  fetch_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), valid,      tbl[i].e_vld);
            chk($sformatf("tbl%0d_count", i), count,      tbl[i].e_cnt);
            chk($sformatf("tbl%0d_pc", i),    pc_o,       tbl[i].e_pc);
            chk($sformatf("tbl%0d_instr", i), ins_o,      tbl[i].e_ins);
            nxt();
        end

        // Flush to 0x200 while 0x88 is in flight: 0x88 data dropped
        do_reset();
        drv(0, 0, 0, 0, 0, 0);                chk("fo_addr0", fetch_addr, 32'h80); nxt();
        drv(0, 1, instr_of(32'h80), 0, 0, 0); chk("fo_addr1", fetch_addr, 32'h84); nxt();
        drv(0, 1, instr_of(32'h84), 0, 0, 0); chk("fo_addr2", fetch_addr, 32'h88);
        chk("fo_en2", fetch_en, 1); nxt();
        drv(1, 0, 0, 0, 1, 32'h200);          chk("fo_en_flush", fetch_en, 0); nxt();
        drv(0, 1, instr_of(32'h88), 0, 0, 0); chk("fo_en_discard", fetch_en, 0);
        chk("fo_cnt_discard", count, 0); nxt();
        drv(0, 0, 0, 0, 0, 0);                chk("fo_cnt_after_drop", count, 0);
        chk("fo_en_after", fetch_en, 1); chk("fo_addr_after", fetch_addr, 32'h200); nxt();
        drv(0, 1, instr_of(32'h200), 0, 0, 0); chk("fo_valid_ret_cycle", valid, BYP); nxt();
        drv(1, 0, 0, 0, 0, 0);                chk("fo_valid", valid, 1);
        chk("fo_pc", pc_o, 32'h200); chk("fo_instr", ins_o, instr_of(32'h200));
        chk("fo_cnt", count, 1); nxt();

        // Flush with simultaneous push and pop at count 2
        do_reset();
        drv(0, 0, 0, 0, 0, 0); nxt();
        drv(0, 1, instr_of(32'h80), 0, 0, 0); nxt();
        drv(0, 1, instr_of(32'h84), 0, 0, 0); nxt();
        drv(0, 1, instr_of(32'h88), 1, 1, 32'h300); chk("fpp_cnt_before", count, 2);
        chk("fpp_valid_hold", valid, 1); nxt();
        drv(1, 0, 0, 0, 0, 0); chk("fpp_cnt", count, 0); chk("fpp_valid", valid, 0);
        chk("fpp_en", fetch_en, 1); chk("fpp_addr", fetch_addr, 32'h300); nxt();

        // Reset mid-fetch: late data without a post-reset issue is dropped
        do_reset();
        drv(0, 0, 0, 0, 0, 0); nxt();
        rst = 1'b1;
        drv(1, 0, 0, 0, 0, 0); nxt();
        rst = 1'b0;
        drv(1, 1, instr_of(32'h80), 1, 0, 0); chk("rmf_valid0", valid, 0); nxt();
        drv(1, 0, 0, 0, 0, 0); chk("rmf_cnt", count, 0); chk("rmf_valid", valid, 0);
        chk("rmf_addr", fetch_addr, 32'h80); nxt();

`ifdef BETA_PB_BYPASS_EN
        do_reset();
        drv(0, 0, 0, 0, 0, 0); nxt();
        drv(1, 1, 32'h0050_0093, 1, 0, 0);
        chk("byp_valid", valid, 1); chk("byp_instr", ins_o, 32'h0050_0093);
        chk("byp_pc", pc_o, 32'h80); chk("byp_cnt0", count, 0); nxt();
        drv(1, 0, 0, 0, 0, 0); chk("byp_cnt", count, 0); chk("byp_valid_next", valid, 0); nxt();
`endif

        // Randomized run against the queue model
        do_reset();
        q.delete(); m_pc = 32'h80; m_pend = 0; m_out = 0; m_disc = 0;
        begin
            int          fu_cnt = 0;
            logic [31:0] fu_pc = 0;
            bit          iss_prev = 0;
            logic [31:0] iss_addr = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                int          sz;
                bit          acc, byp, e_en, e_vld, iss;
                pb_entry_t   hd;
                logic        b, n, r, f;
                logic [31:0] ins, fpc;
                if (iss_prev) begin fu_pc = iss_addr; fu_cnt = int'($urandom_range(1, 3)); end
                n = 0; b = 0; ins = $urandom;
                if (fu_cnt > 0) begin
                    fu_cnt--;
                    if (fu_cnt == 0) begin n = 1; ins = instr_of(fu_pc); end
                    else b = 1;
                end else b = ($urandom % 4 == 0);
                r   = ($urandom % 3 != 0);
                f   = ($urandom % 20 == 0);
                fpc = $urandom & 32'hFFFF_FFFC;
                drv(b, n, ins, r, f, fpc);

                sz    = q.size();
                acc   = n && m_out && !m_disc && !f;
                byp   = BYP && acc && (sz == 0);
                e_en  = ((sz + int'(m_out)) < DEPTH) && !f && !m_disc;
                e_vld = (sz != 0) || byp;
                if (sz != 0)  hd = q[0];
                else if (byp) hd = '{pc: m_pend, instr: ins};
                else          hd = '{pc: 32'h0, instr: NOP};
                chk("rnd_en",    fetch_en,   e_en);
                chk("rnd_addr",  fetch_addr, m_pc);
                chk("rnd_valid", valid,      e_vld);
                chk("rnd_count", count,      sz);
                chk("rnd_pc",    pc_o,       hd.pc);
                chk("rnd_instr", ins_o,      hd.instr);

                iss_prev = fetch_en && !b;
                iss_addr = fetch_addr;
                if (f) begin
                    q.delete();
                    m_pc = fpc;
                    if (n) begin m_out = 0; m_disc = 0; end
                    else if (m_out) m_disc = 1;
                end else begin
                    iss = e_en && !b;
                    if (e_vld && r && sz > 0) void'(q.pop_front());
                    if (acc && !(byp && r)) q.push_back('{pc: m_pend, instr: ins});
                    if (n) begin m_out = 0; m_disc = 0; end
                    if (iss) begin m_pend = m_pc; m_pc = m_pc + 32'd4; m_out = 1; end
                end
                nxt();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
